// File: rtl/pc_sequencer.sv
// Fetch-side PC controller: owns the architectural PC and sequences boot, sequential
// fetch, branch redirect with a single flush bubble, stall and halt/resume.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [0:31] br_target,
    input  logic        halt,
    input  logic        resume,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [0:31] imem_addr,
    output logic        fetch_valid,
    output logic [0:31] fetch_pc,
    output logic        halted,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        REDIR = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state;
    logic [0:31] pc;
    logic [0:31] br_aligned;

    // Handshake: imem_req may drop in any cycle; a transfer happens only on an edge
    // where imem_req and imem_ack are both high, and that edge advances the PC.
    assign imem_req   = (state == FETCH) & ~stall & ~br_valid & ~halt;
    assign imem_addr  = pc;
    assign fsm_state  = state;
    // Bit 0 is the MSB, so the two word-offset bits sit at the right-hand end.
    assign br_aligned = br_target & 32'hFFFF_FFFC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            fetch_valid <= 1'b0;
            fetch_pc    <= RESET_PC;
            halted      <= 1'b0;
        end else begin
            fetch_valid <= 1'b0;
            case (state)
                BOOT: begin
                    state  <= FETCH;
                    halted <= 1'b0;
                end
                FETCH: begin
                    if (br_valid) begin
                        pc    <= br_aligned;
                        state <= REDIR;
                    end else if (halt) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (!stall && imem_ack) begin
                        pc          <= pc + PC_INC;
                        fetch_pc    <= pc;
                        fetch_valid <= 1'b1;
                    end
                end
                REDIR: begin
                    if (br_valid) begin
                        pc <= br_aligned;
                    end else if (halt) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        state <= FETCH;
                    end
                end
                HALT: begin
                    // Simultaneous halt and resume keeps the core parked.
                    if (resume && !halt) begin
                        state  <= FETCH;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= BOOT;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, stall/ack gaps, redirect, halt/resume,
// PC wrap-around and asynchronous mid-run reset.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        br_valid = 1'b0;
    logic [0:31] br_target = 32'h0;
    logic        halt = 1'b0;
    logic        resume = 1'b0;
    logic        imem_ack = 1'b1;
    logic        imem_req;
    logic [0:31] imem_addr;
    logic        fetch_valid;
    logic [0:31] fetch_pc;
    logic        halted;
    logic [1:0]  fsm_state;

    int total = 0;
    int bad = 0;

    pc_sequencer #(.RESET_PC(32'h0000_00C8), .PC_INC(32'd4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .br_target(br_target),
        .halt(halt), .resume(resume), .imem_ack(imem_ack), .imem_req(imem_req),
        .imem_addr(imem_addr), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .halted(halted), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        total++; if (fsm_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", fsm_state); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0b want=0", imem_req); end
        total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL reset_fv got=%0b want=0", fetch_valid); end
        total++; if (fetch_pc !== 32'h0000_00C8) begin bad++; $display("FAIL reset_fpc got=%h want=000000c8", fetch_pc); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%0b want=0", halted); end
        total++; if (imem_addr !== 32'h0000_00C8) begin bad++; $display("FAIL reset_addr got=%h want=000000c8", imem_addr); end
    endtask

    // Releases reset just after an edge and follows the first three fetch cycles.
    task automatic run_boot(input string tag);
        @(posedge clk);
        #1 rst = 1'b0;
        imem_ack = 1'b1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL %s_boot_req got=%0b want=0", tag, imem_req); end
        step();
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL %s_req1 got=%0b want=1", tag, imem_req); end
        total++; if (imem_addr !== 32'h0000_00C8) begin bad++; $display("FAIL %s_addr1 got=%h want=000000c8", tag, imem_addr); end
        total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL %s_fv1 got=%0b want=0", tag, fetch_valid); end
        step();
        total++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0000_00C8) begin bad++; $display("FAIL %s_dlv1 got=%0b/%h want=1/000000c8", tag, fetch_valid, fetch_pc); end
        total++; if (imem_addr !== 32'h0000_00CC) begin bad++; $display("FAIL %s_addr2 got=%h want=000000cc", tag, imem_addr); end
        step();
        total++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0000_00CC) begin bad++; $display("FAIL %s_dlv2 got=%0b/%h want=1/000000cc", tag, fetch_valid, fetch_pc); end
        total++; if (imem_addr !== 32'h0000_00D0) begin bad++; $display("FAIL %s_addr3 got=%h want=000000d0", tag, imem_addr); end
    endtask

    task automatic test_stall_gaps();
        int d0_count = 0;
        stall = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req_comb got=%0b want=0", imem_req); end
        for (int i = 0; i < 3; i++) begin
            step();
            if (fetch_valid === 1'b1 && fetch_pc === 32'h0000_00D0) d0_count++;
            total++; if (imem_req !== 1'b0 || imem_addr !== 32'h0000_00D0) begin bad++; $display("FAIL stall_hold%0d got=%0b/%h want=0/000000d0", i, imem_req, imem_addr); end
        end
        stall = 1'b0;
        imem_ack = 1'b0;
        #1;
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL noack_req got=%0b want=1", imem_req); end
        for (int i = 0; i < 2; i++) begin
            step();
            if (fetch_valid === 1'b1 && fetch_pc === 32'h0000_00D0) d0_count++;
            total++; if (fetch_valid !== 1'b0 || imem_addr !== 32'h0000_00D0) begin bad++; $display("FAIL noack_hold%0d got=%0b/%h want=0/000000d0", i, fetch_valid, imem_addr); end
        end
        imem_ack = 1'b1;
        step();
        if (fetch_valid === 1'b1 && fetch_pc === 32'h0000_00D0) d0_count++;
        total++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0000_00D0) begin bad++; $display("FAIL gap_dlv_d0 got=%0b/%h want=1/000000d0", fetch_valid, fetch_pc); end
        step();
        if (fetch_valid === 1'b1 && fetch_pc === 32'h0000_00D0) d0_count++;
        total++; if (fetch_pc !== 32'h0000_00D4 || imem_addr !== 32'h0000_00D8) begin bad++; $display("FAIL gap_next got=%h/%h want=000000d4/000000d8", fetch_pc, imem_addr); end
        total++; if (d0_count !== 1) begin bad++; $display("FAIL d0_once got=%0d want=1", d0_count); end
    endtask

    task automatic test_branch();
        step();
        step();
        total++; if (imem_addr !== 32'h0000_00E0 || imem_req !== 1'b1) begin bad++; $display("FAIL br_pre got=%h/%0b want=000000e0/1", imem_addr, imem_req); end
        br_valid = 1'b1;
        br_target = 32'h0000_1003;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL br_req_mask got=%0b want=0", imem_req); end
        step();
        br_valid = 1'b0;
        total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL br_e0_dropped got=%0b want=0", fetch_valid); end
        total++; if (fsm_state !== 2'd2 || imem_req !== 1'b0) begin bad++; $display("FAIL br_bubble got=%0d/%0b want=2/0", fsm_state, imem_req); end
        total++; if (imem_addr !== 32'h0000_1000) begin bad++; $display("FAIL br_align got=%h want=00001000", imem_addr); end
        step();
        total++; if (fetch_valid !== 1'b0 || imem_req !== 1'b1) begin bad++; $display("FAIL br_first_req got=%0b/%0b want=0/1", fetch_valid, imem_req); end
        step();
        total++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0000_1000) begin bad++; $display("FAIL br_dlv0 got=%0b/%h want=1/00001000", fetch_valid, fetch_pc); end
        step();
        total++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0000_1004) begin bad++; $display("FAIL br_dlv1 got=%0b/%h want=1/00001004", fetch_valid, fetch_pc); end
    endtask

    task automatic test_redir_reload();
        br_valid = 1'b1;
        br_target = 32'h0000_0200;
        step();
        br_target = 32'h0000_0300;
        step();
        br_valid = 1'b0;
        total++; if (fsm_state !== 2'd2 || imem_addr !== 32'h0000_0300) begin bad++; $display("FAIL reload got=%0d/%h want=2/00000300", fsm_state, imem_addr); end
        step();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0300) begin bad++; $display("FAIL reload_req got=%0b/%h want=1/00000300", imem_req, imem_addr); end
    endtask

    task automatic test_halt_resume();
        br_valid = 1'b1;
        br_target = 32'h0000_0100;
        step();
        br_valid = 1'b0;
        step();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin bad++; $display("FAIL halt_pre got=%0b/%h want=1/00000100", imem_req, imem_addr); end
        halt = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL halt_req_comb got=%0b want=0", imem_req); end
        step();
        halt = 1'b0;
        total++; if (halted !== 1'b1 || fetch_valid !== 1'b0) begin bad++; $display("FAIL halt_enter got=%0b/%0b want=1/0", halted, fetch_valid); end
        for (int i = 0; i < 5; i++) begin
            br_valid = (i == 2);
            br_target = 32'h0000_2000;
            stall = (i == 3);
            step();
            total++; if (halted !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 32'h0000_0100) begin bad++; $display("FAIL halt_hold%0d got=%0b/%0b/%h want=1/0/00000100", i, halted, imem_req, imem_addr); end
        end
        br_valid = 1'b0;
        stall = 1'b0;
        halt = 1'b1;
        resume = 1'b1;
        step();
        total++; if (halted !== 1'b1 || fsm_state !== 2'd3) begin bad++; $display("FAIL halt_and_resume got=%0b/%0d want=1/3", halted, fsm_state); end
        halt = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL resume_same_cycle got=%0b want=0", imem_req); end
        step();
        resume = 1'b0;
        total++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin bad++; $display("FAIL resume_req got=%0b/%0b/%h want=0/1/00000100", halted, imem_req, imem_addr); end
        step();
        total++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0000_0100) begin bad++; $display("FAIL resume_dlv got=%0b/%h want=1/00000100", fetch_valid, fetch_pc); end
    endtask

    task automatic test_wrap();
        br_valid = 1'b1;
        br_target = 32'hFFFF_FFF8;
        step();
        br_valid = 1'b0;
        total++; if (fetch_valid !== 1'b0 || fsm_state !== 2'd2) begin bad++; $display("FAIL wrap_bubble got=%0b/%0d want=0/2", fetch_valid, fsm_state); end
        step();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_req got=%0b/%h want=1/fffffff8", imem_req, imem_addr); end
        step();
        total++; if (fetch_pc !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_dlv0 got=%h want=fffffff8", fetch_pc); end
        step();
        total++; if (fetch_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0000_0000) begin bad++; $display("FAIL wrap_dlv1 got=%h/%h want=fffffffc/00000000", fetch_pc, imem_addr); end
        step();
        total++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0000_0000 || imem_addr !== 32'h0000_0004) begin bad++; $display("FAIL wrap_dlv2 got=%0b/%h/%h want=1/00000000/00000004", fetch_valid, fetch_pc, imem_addr); end
    endtask

    task automatic test_mid_reset();
        #2 rst = 1'b1;
        #1;
        total++; if (fetch_valid !== 1'b0 || imem_req !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL midrst_outs got=%0b/%0b/%0b want=0/0/0", fetch_valid, imem_req, halted); end
        total++; if (fetch_pc !== 32'h0000_00C8 || imem_addr !== 32'h0000_00C8) begin bad++; $display("FAIL midrst_pc got=%h/%h want=000000c8/000000c8", fetch_pc, imem_addr); end
        run_boot("reboot");
    endtask

    initial begin
        test_reset();
        run_boot("boot");
        test_stall_gaps();
        test_branch();
        test_redir_reload();
        test_halt_resume();
        test_wrap();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
